// File: rtl/hus_tick_gen.sv
// HUS sound engine timing and channel sequencer: prescaler, sample/tick strobes,
// reload-mask capture and a one-channel-per-clock scan after every sample.
module hus_tick_gen #(
  parameter int PRESCALE = 28,
  parameter int CHANNELS = 32
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic [31:0] reload,
  input  logic [7:0]  sample_rate,
  input  logic [9:0]  tick_rate,
  output logic        sample_stb,
  output logic        tick_stb,
  output logic        chan_stb,
  output logic [4:0]  chan_num,
  output logic        chan_reload,
  output logic        overrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [4:0]    CHAN_LAST = 5'(CHANNELS - 1);
  localparam logic [31:0]   CHAN_MASK = (CHANNELS >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << CHANNELS) - 32'd1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]     smp_cnt_q, smp_cnt_d;
  logic [9:0]     tck_cnt_q, tck_cnt_d;
  logic           sample_stb_q, sample_stb_d;
  logic           tick_stb_q, tick_stb_d;
  logic [4:0]     chan_num_q, chan_num_d;
  logic [31:0]    reload_lat_q, reload_lat_d;
  logic           overrun_q, overrun_d;
  logic           pre_stb, smp_evt, tck_evt;
  logic [31:0]    clear_mask, capture_mask;

  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    tck_cnt_d    = tck_cnt_q;
    state_d      = state_q;
    chan_num_d   = chan_num_q;
    overrun_d    = overrun_q;
    smp_evt      = 1'b0;
    tck_evt      = 1'b0;
    clear_mask   = '0;
    capture_mask = '0;

    pre_stb = (pre_cnt_q == PRE_LAST);
    if (pre_stb) pre_cnt_d = '0;
    else         pre_cnt_d = pre_cnt_q + PW'(1);

    // >= rather than == so a lowered rate wraps at once instead of rolling past 255
    if (pre_stb) begin
      if (smp_cnt_q >= sample_rate) begin
        smp_cnt_d = '0;
        smp_evt   = 1'b1;
      end else begin
        smp_cnt_d = smp_cnt_q + 8'd1;
      end
    end

    if (smp_evt) begin
      if (tck_cnt_q >= tick_rate) begin
        tck_cnt_d = '0;
        tck_evt   = 1'b1;
      end else begin
        tck_cnt_d = tck_cnt_q + 10'd1;
      end
    end

    sample_stb_d = smp_evt;
    tick_stb_d   = tck_evt;

    case (state_q)
      IDLE: begin
        if (sample_stb_q) begin
          state_d    = SCAN;
          chan_num_d = '0;
        end
      end
      SCAN: begin
        clear_mask[chan_num_q] = 1'b1;
        if (sample_stb_q) overrun_d = 1'b1;
        if (chan_num_q == CHAN_LAST) begin
          state_d    = IDLE;
          chan_num_d = '0;
        end else begin
          chan_num_d = chan_num_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture is OR-ed in after the clear so a bit re-requested on this tick survives
    if (tick_stb_q) capture_mask = reload & CHAN_MASK;
    reload_lat_d = (reload_lat_q & ~clear_mask) | capture_mask;

    if (!enable) begin
      pre_cnt_d    = '0;
      smp_cnt_d    = '0;
      tck_cnt_d    = '0;
      sample_stb_d = 1'b0;
      tick_stb_d   = 1'b0;
      state_d      = IDLE;
      chan_num_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      tck_cnt_q    <= '0;
      sample_stb_q <= 1'b0;
      tick_stb_q   <= 1'b0;
      chan_num_q   <= '0;
      reload_lat_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      tck_cnt_q    <= tck_cnt_d;
      sample_stb_q <= sample_stb_d;
      tick_stb_q   <= tick_stb_d;
      chan_num_q   <= chan_num_d;
      reload_lat_q <= reload_lat_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample_stb  = sample_stb_q;
  assign tick_stb    = tick_stb_q;
  assign chan_stb    = (state_q == SCAN);
  assign chan_num    = chan_num_q;
  assign chan_reload = (state_q == SCAN) & reload_lat_q[chan_num_q];
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hus_tick_gen.sv
// Self-checking bench for hus_tick_gen: directed period/scan/control checks plus a
// randomized run compared every clock against a behavioural model.
module tb_hus_tick_gen;

  localparam int PRE  = 28;
  localparam int CH   = 32;
  localparam int PRE2 = 20;

  logic        clk = 1'b0;
  logic        res, res2, enable;
  logic [31:0] reload;
  logic [7:0]  sample_rate;
  logic [9:0]  tick_rate;

  logic        sample_stb, tick_stb, chan_stb, chan_reload, overrun;
  logic [4:0]  chan_num;
  logic        sample_stb2, tick_stb2, chan_stb2, chan_reload2, overrun2;
  logic [4:0]  chan_num2;

  int compared   = 0;
  int mismatched = 0;

  int          m_phase, m_step, m_samples, m_scan;
  logic [31:0] m_pend;
  bit          m_smp, m_tck, m_over;

  always #5 clk = ~clk;

  hus_tick_gen #(.PRESCALE(PRE), .CHANNELS(CH)) dut (
    .clk(clk), .res(res), .enable(enable), .reload(reload),
    .sample_rate(sample_rate), .tick_rate(tick_rate),
    .sample_stb(sample_stb), .tick_stb(tick_stb), .chan_stb(chan_stb),
    .chan_num(chan_num), .chan_reload(chan_reload), .overrun(overrun)
  );

  hus_tick_gen #(.PRESCALE(PRE2), .CHANNELS(CH)) dut_fast (
    .clk(clk), .res(res2), .enable(enable), .reload(reload),
    .sample_rate(sample_rate), .tick_rate(tick_rate),
    .sample_stb(sample_stb2), .tick_stb(tick_stb2), .chan_stb(chan_stb2),
    .chan_num(chan_num2), .chan_reload(chan_reload2), .overrun(overrun2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [31:0] rl,
                               input logic [7:0] sr, input logic [9:0] tr);
    res = r; enable = en; reload = rl; sample_rate = sr; tick_rate = tr;
  endtask

  // Reference: counts clocks per base step, base steps per sample, samples per tick,
  // and tracks the pending reload set plus the current scan position.
  task automatic modelEdge();
    logic [31:0] np;
    int          nscan;
    bit          evt, tevt;
    if (res) begin
      m_phase = 0; m_step = 0; m_samples = 0; m_scan = -1;
      m_pend = '0; m_smp = 0; m_tck = 0; m_over = 0;
    end else begin
      np = m_pend;
      if (m_scan >= 0) np[m_scan] = 1'b0;
      if (m_tck) np = np | reload;
      nscan = m_scan;
      if (m_scan >= 0) begin
        if (m_smp) m_over = 1;
        nscan = (m_scan == CH - 1) ? -1 : m_scan + 1;
      end else if (m_smp) begin
        nscan = 0;
      end
      evt = 0; tevt = 0;
      if (!enable) begin
        m_phase = 0; m_step = 0; m_samples = 0; nscan = -1;
      end else begin
        if (m_phase == PRE - 1) begin
          m_phase = 0;
          if (m_step >= int'(sample_rate)) begin m_step = 0; evt = 1; end
          else m_step++;
        end else begin
          m_phase++;
        end
        if (evt) begin
          if (m_samples >= int'(tick_rate)) begin m_samples = 0; tevt = 1; end
          else m_samples++;
        end
      end
      m_pend = np; m_scan = nscan; m_smp = evt; m_tck = tevt;
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("sample_stb", {31'd0, sample_stb}, {31'd0, m_smp});
    checkOutput("tick_stb", {31'd0, tick_stb}, {31'd0, m_tck});
    checkOutput("chan_stb", {31'd0, chan_stb}, {31'd0, (m_scan >= 0)});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, m_over});
    if (m_scan >= 0) begin
      checkOutput("chan_num", {27'd0, chan_num}, 32'(m_scan));
      checkOutput("chan_reload", {31'd0, chan_reload}, {31'd0, m_pend[m_scan]});
    end else begin
      checkOutput("chan_reload_idle", {31'd0, chan_reload}, 32'd0);
    end
  endtask

  task automatic waitSample(input int budget, output int n);
    n = 0;
    do begin
      stepClock();
      n++;
    end while (sample_stb !== 1'b1 && n < budget);
    if (sample_stb !== 1'b1) checkOutput("sample_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitTick(input int budget, output int n, output int samples);
    n = 0; samples = 0;
    do begin
      stepClock();
      n++;
      if (sample_stb === 1'b1) samples++;
      if (tick_stb === 1'b1) checkOutput("tick_with_sample", {31'd0, sample_stb}, 32'd1);
    end while (tick_stb !== 1'b1 && n < budget);
    if (tick_stb !== 1'b1) checkOutput("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic collectScan(input string tag, input logic [31:0] exp_mask);
    logic [31:0] mask;
    int          n;
    mask = '0; n = 0;
    while (chan_stb === 1'b1 && n < CH + 8) begin
      if (chan_reload === 1'b1) mask[chan_num] = 1'b1;
      stepClock();
      n++;
    end
    checkOutput({tag, "_len"}, 32'(n), 32'(CH));
    checkOutput({tag, "_mask"}, mask, exp_mask);
  endtask

  initial begin
    int n, s;
    res2 = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 8'd0, 10'd0);
    stepClock();
    stepClock();
    checkOutput("rst_sample_stb", {31'd0, sample_stb}, 32'd0);
    checkOutput("rst_tick_stb", {31'd0, tick_stb}, 32'd0);
    checkOutput("rst_chan_stb", {31'd0, chan_stb}, 32'd0);
    checkOutput("rst_chan_num", {27'd0, chan_num}, 32'd0);
    checkOutput("rst_chan_reload", {31'd0, chan_reload}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);

    res2 = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'd0, 8'd3, 10'd0);
    waitSample(300, n);
    checkOutput("first_sample_delay", 32'(n), 32'd112);
    for (int i = 0; i < 2; i++) begin
      waitSample(300, n);
      checkOutput("sample_period", 32'(n), 32'd112);
      checkOutput("tick_every_sample", {31'd0, tick_stb}, 32'd1);
    end

    applyStimulus(1'b0, 1'b1, 32'd0, 8'd0, 10'd4);
    waitTick(400, n, s);
    for (int i = 0; i < 2; i++) begin
      waitTick(400, n, s);
      checkOutput("tick_period", 32'(n), 32'd140);
      checkOutput("tick_samples", 32'(s), 32'd5);
    end
    checkOutput("overrun_fast_samples", {31'd0, overrun}, 32'd1);

    applyStimulus(1'b0, 1'b1, 32'd0, 8'd3, 10'd0);
    waitSample(300, n);
    waitSample(300, n);
    reload = 32'h8000_0005;
    waitSample(300, n);
    stepClock();
    reload = 32'd0;
    collectScan("scan_reload", 32'h8000_0005);
    waitSample(300, n);
    stepClock();
    collectScan("scan_empty", 32'd0);

    applyStimulus(1'b0, 1'b1, 32'd0, 8'd255, 10'd0);
    waitSample(8000, n);
    for (int i = 0; i < 200 * PRE; i++) stepClock();
    sample_rate = 8'd10;
    waitSample(300, n);
    checkOutput("rate_change_wrap", 32'(n), 32'(PRE));
    waitSample(600, n);
    checkOutput("rate_change_period", 32'(n), 32'(11 * PRE));

    applyStimulus(1'b0, 1'b1, 32'd0, 8'd3, 10'd0);
    waitSample(400, n);
    reload = 32'hFFFF_FFFF;
    waitSample(300, n);
    stepClock();
    reload = 32'd0;
    for (int i = 0; i < 5; i++) stepClock();
    checkOutput("drop_at_chan", {27'd0, chan_num}, 32'd5);
    enable = 1'b0;
    stepClock();
    checkOutput("drop_chan_stb", {31'd0, chan_stb}, 32'd0);
    for (int i = 0; i < 3; i++) stepClock();
    enable = 1'b1;
    waitSample(300, n);
    checkOutput("reenable_delay", 32'(n), 32'd112);
    stepClock();
    collectScan("scan_pending", 32'hFFFF_FFC0);

    for (int i = 0; i < 3000; i++) begin
      reload = $urandom;
      if ($urandom_range(0, 199) == 0) sample_rate = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) tick_rate = 10'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      res = ($urandom_range(0, 499) == 0);
      stepClock();
    end
    res = 1'b0;

    checkOutput("overrun_fast_set", {31'd0, overrun2}, 32'd1);
    res2 = 1'b1;
    stepClock();
    checkOutput("overrun_fast_clear", {31'd0, overrun2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
